// File: rtl/mem_stage_if.sv
// MEM-stage bundle: MEM_* request from EX/MEM, WB_* result to write-back, stall/error status.
// MEM_BYTE_EN adds the MEM_Byte lane-select input.
interface mem_stage_if;
  logic        MEM_RegWr;
  logic [4:0]  MEM_Rw;
  logic [31:0] MEM_Result;
  logic        MEM_MemWr;
  logic        MEM_MemtoReg;
  logic [31:0] MEM_busB;
`ifdef MEM_BYTE_EN
  logic        MEM_Byte;
`endif
  logic        WB_RegWr;
  logic [4:0]  WB_Rw;
  logic [31:0] WB_Data;
  logic        mem_stall;
  logic        addr_err;

  modport master (
    output MEM_RegWr, MEM_Rw, MEM_Result, MEM_MemWr, MEM_MemtoReg, MEM_busB,
`ifdef MEM_BYTE_EN
    output MEM_Byte,
`endif
    input  WB_RegWr, WB_Rw, WB_Data, mem_stall, addr_err
  );

  modport slave (
    input  MEM_RegWr, MEM_Rw, MEM_Result, MEM_MemWr, MEM_MemtoReg, MEM_busB,
`ifdef MEM_BYTE_EN
    input  MEM_Byte,
`endif
    output WB_RegWr, WB_Rw, WB_Data, mem_stall, addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: word RAM with LATENCY-cycle accesses, stall while in flight, registered WB_* bundle.
// Optional MEM_BYTE_EN: byte-lane stores and sign-extended byte loads.
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  mem_stage_if.slave  m
);
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [3:0]        cnt;
  logic              req, mis, done, rw_nz, ram_we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       rd_word, ld_data, wr_word;

  assign req   = m.MEM_MemWr | m.MEM_MemtoReg;
  assign waddr = m.MEM_Result[ADDR_W+1:2];
  assign rw_nz = (m.MEM_Rw != 5'd0);
  assign done  = (cnt == 4'(LATENCY-1));

`ifdef MEM_BYTE_EN
  logic [1:0] lane;
  logic [7:0] rd_byte;
  assign lane    = m.MEM_Result[1:0];
  assign mis     = req & ~m.MEM_Byte & (lane != 2'b00);
  assign rd_word = ram[waddr];
  assign rd_byte = rd_word[lane*8 +: 8];
  assign ld_data = m.MEM_Byte ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
  always_comb begin
    wr_word = m.MEM_busB;
    if (m.MEM_Byte) begin
      wr_word = rd_word;
      wr_word[lane*8 +: 8] = m.MEM_busB[7:0];
    end
  end
`else
  assign mis     = req & (m.MEM_Result[1:0] != 2'b00);
  assign rd_word = ram[waddr];
  assign ld_data = rd_word;
  assign wr_word = m.MEM_busB;
`endif

  assign m.mem_stall = req & ~mis & ~done;
  assign ram_we      = run & m.MEM_MemWr & ~mis & done;

  // RAM is deliberately not reset; reset still blocks a pending store
  always_ff @(posedge clk)
    if (rst_n && ram_we) ram[waddr] <= wr_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      m.WB_RegWr <= 1'b0;
      m.WB_Rw    <= 5'd0;
      m.WB_Data  <= 32'd0;
      m.addr_err <= 1'b0;
    end else if (run) begin
      m.addr_err <= mis;
      if (!req || mis) begin
        cnt        <= 4'd0;
        m.WB_RegWr <= ~mis & m.MEM_RegWr & rw_nz;
        m.WB_Rw    <= m.MEM_Rw;
        m.WB_Data  <= m.MEM_Result;
      end else if (!done) begin
        cnt        <= cnt + 4'd1;
        m.WB_RegWr <= 1'b0;
      end else begin
        cnt     <= 4'd0;
        m.WB_Rw <= m.MEM_Rw;
        // store wins when both MemWr and MemtoReg are set
        if (m.MEM_MemWr) begin
          m.WB_RegWr <= 1'b0;
          m.WB_Data  <= m.MEM_Result;
        end else begin
          m.WB_RegWr <= m.MEM_RegWr & rw_nz;
          m.WB_Data  <= ld_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: one LATENCY=2 and one LATENCY=4 instance.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b1;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] data;
    logic        aerr;
    int          stalls;
  } exp_t;
  exp_t sb[$];

  mem_stage_if i2 ();
  mem_stage_if i4 ();

  mem_stage #(.ADDR_W(8), .LATENCY(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .run(run), .m(i2.slave));
  mem_stage #(.ADDR_W(8), .LATENCY(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .run(run), .m(i4.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic regwr, input logic [4:0] rw, input logic [31:0] res,
                       input logic memwr, input logic memtoreg, input logic [31:0] busb);
    if (d == 2) begin
      i2.MEM_RegWr = regwr; i2.MEM_Rw = rw; i2.MEM_Result = res;
      i2.MEM_MemWr = memwr; i2.MEM_MemtoReg = memtoreg; i2.MEM_busB = busb;
    end else begin
      i4.MEM_RegWr = regwr; i4.MEM_Rw = rw; i4.MEM_Result = res;
      i4.MEM_MemWr = memwr; i4.MEM_MemtoReg = memtoreg; i4.MEM_busB = busb;
    end
  endtask

  function automatic logic stall_of(input int d);
    return (d == 2) ? i2.mem_stall : i4.mem_stall;
  endfunction

  task automatic check_wb(input int d, input string tag, input exp_t e);
    if (d == 2) begin
      chk({tag, ".regwr"}, 32'(i2.WB_RegWr), 32'(e.regwr));
      chk({tag, ".rw"},    32'(i2.WB_Rw),    32'(e.rw));
      chk({tag, ".data"},  i2.WB_Data,       e.data);
      chk({tag, ".aerr"},  32'(i2.addr_err), 32'(e.aerr));
    end else begin
      chk({tag, ".regwr"}, 32'(i4.WB_RegWr), 32'(e.regwr));
      chk({tag, ".rw"},    32'(i4.WB_Rw),    32'(e.rw));
      chk({tag, ".data"},  i4.WB_Data,       e.data);
      chk({tag, ".aerr"},  32'(i4.addr_err), 32'(e.aerr));
    end
  endtask

  // present one op, push its expected result, walk the stall, then pop/compare on completion
  task automatic issue(input int d, input string tag, input logic regwr, input logic [4:0] rw,
                       input logic [31:0] res, input logic memwr, input logic memtoreg,
                       input logic [31:0] busb, input logic e_regwr, input logic [31:0] e_data,
                       input logic e_aerr, input int e_stalls);
    exp_t e;
    int n;
    e.regwr = e_regwr; e.rw = rw; e.data = e_data; e.aerr = e_aerr; e.stalls = e_stalls;
    sb.push_back(e);
    drive(d, regwr, rw, res, memwr, memtoreg, busb);
    #1;
    n = 0;
    while (stall_of(d) && n < 20) begin
      @(posedge clk); #1;
      n++;
      chk({tag, ".bubble"}, 32'((d == 2) ? i2.WB_RegWr : i4.WB_RegWr), 32'd0);
    end
    chk({tag, ".stalls"}, 32'(n), 32'(e.stalls));
    @(posedge clk); #1;
    e = sb.pop_front();
    check_wb(d, tag, e);
    drive(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    exp_t z;
    z.regwr = 1'b0; z.rw = 5'd0; z.data = 32'd0; z.aerr = 1'b0; z.stalls = 0;
    drive(2, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_wb(2, "reset2", z);
    check_wb(4, "reset4", z);
    rst_n = 1'b1;

    issue(2, "alu", 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1234, 1'b0, 0);
    issue(2, "alu_r0", 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 32'd0, 1'b0, 32'h55, 1'b0, 0);
    issue(2, "st10", 1'b0, 5'd0, 32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h10, 1'b0, 1);
    issue(2, "ld10", 1'b1, 5'd3, 32'h10, 1'b0, 1'b1, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1);

    issue(2, "mis13", 1'b1, 5'd4, 32'h13, 1'b0, 1'b1, 32'd0, 1'b0, 32'h13, 1'b1, 0);
    @(posedge clk); #1;
    chk("mis13.clear", 32'(i2.addr_err), 32'd0);
    issue(2, "ld10b", 1'b1, 5'd6, 32'h10, 1'b0, 1'b1, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1);

    issue(2, "st400", 1'b0, 5'd0, 32'h400, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h400, 1'b0, 1);
    issue(2, "ld000", 1'b1, 5'd8, 32'h000, 1'b0, 1'b1, 32'd0, 1'b1, 32'hA5A5A5A5, 1'b0, 1);
    issue(2, "stld", 1'b1, 5'd9, 32'h40, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, 32'h40, 1'b0, 1);
    issue(2, "ld40", 1'b1, 5'd10, 32'h40, 1'b0, 1'b1, 32'd0, 1'b1, 32'h0BADF00D, 1'b0, 1);

    // LATENCY=4: freeze mid-stall with run=0
    issue(4, "st4", 1'b0, 5'd0, 32'h40, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 32'h40, 1'b0, 3);
    @(posedge clk); #1;
    check_wb(4, "nop4", z);
    drive(4, 1'b1, 5'd9, 32'h40, 1'b0, 1'b1, 32'd0);
    #1;
    chk("frz.stall0", 32'(i4.mem_stall), 32'd1);
    @(posedge clk); #1;
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("frz.stall", 32'(i4.mem_stall), 32'd1);
      check_wb(4, "frz", z);
    end
    run = 1'b1;
    @(posedge clk); #1;
    chk("frz.res1", 32'(i4.mem_stall), 32'd1);
    check_wb(4, "frz.res1", z);
    @(posedge clk); #1;
    chk("frz.res2", 32'(i4.mem_stall), 32'd0);
    chk("frz.res2.regwr", 32'(i4.WB_RegWr), 32'd0);
    @(posedge clk); #1;
    z.regwr = 1'b1; z.rw = 5'd9; z.data = 32'hCAFEF00D;
    check_wb(4, "frz.done", z);
    drive(4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    z.regwr = 1'b0; z.rw = 5'd0; z.data = 32'd0;

    // reset in the WAIT of a store must abort it
    issue(2, "st20", 1'b0, 5'd7, 32'h20, 1'b1, 1'b0, 32'h11111111, 1'b0, 32'h20, 1'b0, 1);
    drive(2, 1'b0, 5'd7, 32'h20, 1'b1, 1'b0, 32'h22222222);
    @(posedge clk); #1;
    chk("rst.wait.stall", 32'(i2.mem_stall), 32'd0);
    chk("rst.wait.rw", 32'(i2.WB_Rw), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check_wb(2, "rst.async", z);
    drive(2, 1'b1, 5'd3, 32'h20, 1'b0, 1'b1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(2, "ld20", 1'b1, 5'd3, 32'h20, 1'b0, 1'b1, 32'd0, 1'b1, 32'h11111111, 1'b0, 1);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage CPU.
- Consumes the MEM_* bundle produced by the EX/MEM register and performs data-memory loads and stores against an internal word RAM with configurable access latency.
- Asserts a stall back to the front of the pipe while an access is in flight.
- Drives the registered WB_* bundle consumed by the write-back stage.

Parameters:
- ADDR_W, 8, word-address width; RAM holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles per memory access (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  global enable; 0 freezes all state.
- MEM_RegWr  in  1  instruction writes a register.
- MEM_Rw  in  5  destination register.
- MEM_Result  in  32  ALU result: byte address for memory ops, write-back value otherwise.
- MEM_MemWr  in  1  store.
- MEM_MemtoReg  in  1  load.
- MEM_busB  in  32  store data.
- WB_RegWr  out  1  registered write-back enable.
- WB_Rw  out  5  registered destination register.
- WB_Data  out  32  registered write-back value.
- mem_stall  out  1  combinational; upstream holds the MEM_* bundle stable while high.
- addr_err  out  1  registered one-cycle pulse on a misaligned access.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - WB_RegWr=0, WB_Rw=0, WB_Data=0, addr_err=0, cnt=0.
  - RAM contents are not reset.
  - Reset mid-access aborts the access; a pending store is not written.
- Definitions:
  - req = MEM_MemWr | MEM_MemtoReg.
  - waddr = MEM_Result[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo RAM size.
  - mis = req & (MEM_Result[1:0]!=0).
- Latency counter cnt:
  - Width 4; sole state is IDLE (cnt=0) / WAIT (cnt>0).
  - mem_stall = req & ~mis & (cnt != LATENCY-1).
  - With LATENCY=1, mem_stall is never asserted.
- Each rising edge with run=1:
  - Non-memory op (req=0): WB_RegWr<=MEM_RegWr, WB_Rw<=MEM_Rw, WB_Data<=MEM_Result, cnt<=0. One-cycle latency.
  - Misaligned (mis=1): no RAM access, addr_err<=1, WB_RegWr<=0, WB_Rw<=MEM_Rw, WB_Data<=MEM_Result, cnt<=0.
  - Memory op, cnt<LATENCY-1: cnt<=cnt+1, WB_RegWr<=0 (bubble), WB_Rw and WB_Data hold.
  - Memory op, cnt==LATENCY-1 (completion edge): cnt<=0.
    - Store: RAM[waddr]<=MEM_busB, WB_RegWr<=0, WB_Data<=MEM_Result.
    - Load: WB_Data<=RAM[waddr] (pre-edge contents), WB_RegWr<=MEM_RegWr.
    - WB_Rw<=MEM_Rw in both cases.
  - addr_err<=0 on every edge that is not misaligned.
- Total memory-op latency: LATENCY edges from first presentation; mem_stall high for LATENCY-1 cycles.
- MemWr and MemtoReg both set: treated as store; no load data returned; WB_RegWr=0.
- MEM_Rw==0 forces WB_RegWr to 0 on every edge.
- run=0: no update of cnt, RAM, or any registered output. An in-flight access resumes at the same count when run returns to 1. mem_stall still evaluates combinationally.
- Inputs changing while mem_stall=1 is an upstream protocol violation; behaviour is undefined and the bench must not check it.

Optional Feature:
- Macro: MEM_BYTE_EN.
- Defined:
  - Adds input MEM_Byte (1 bit).
  - When MEM_Byte=1, alignment check is skipped and lane = MEM_Result[1:0].
  - Store writes only byte lane `lane` of RAM[waddr] with MEM_busB[7:0]; other bytes are unchanged.
  - Load returns that byte sign-extended to 32 bits.
  - Latency and stall rules are unchanged.
- Undefined: port absent; word accesses only.

Test Plan:
- Reset then ALU op (RegWr=1, Rw=5, Result=0x1234) -> next edge WB_RegWr=1, WB_Rw=5, WB_Data=0x1234, mem_stall=0 throughout.
- LATENCY=2: store busB=0xDEADBEEF @Result=0x10, then load @0x10 Rw=3 -> each op has mem_stall=1 for exactly 1 cycle; WB_RegWr=0 on the store completion edge; load completes with WB_Data=0xDEADBEEF, WB_RegWr=1, WB_Rw=3.
- Load @Result=0x13 -> addr_err=1 for one cycle, WB_RegWr=0, no stall, RAM unchanged.
- Address wrap (ADDR_W=8): store 0xA5A5A5A5 @0x400, load @0x000 -> WB_Data=0xA5A5A5A5.
- run=0 for 3 cycles mid-stall with LATENCY=4 -> cnt frozen; after run=1, completion exactly at remaining count; WB_* unchanged while frozen.
- rst_n low for one cycle during the WAIT of a store @0x20 (RAM previously 0x11111111), then load @0x20 -> WB_Data=0x11111111; all outputs 0 immediately on reset assertion.
